// File: rtl/mc_axil_fifo_bridge.sv
// AXI4-Lite slave that connects a host CPU to two word FIFOs (host-to-PL and PL-to-host).
// It also provides occupancy, control and sticky error registers.

module mc_axil_fifo_bridge_fifo #(
   parameter int W   = 32,
   parameter int ELS = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clr_i,
   input  logic                 enq_i,
   input  logic                 deq_i,
   input  logic [W-1:0]         data_i,
   output logic [W-1:0]         data_o,
   output logic [$clog2(ELS):0] count_o,
   output logic                 full_o,
   output logic                 empty_o
);
   localparam int PW = $clog2(ELS);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem_q [ELS];
   logic [W-1:0]  mem_d [ELS];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   // storage, pointer and count next-state; clear discards same-cycle traffic
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr_i) begin
         wr_ptr_d = {PW{1'b0}};
         rd_ptr_d = {PW{1'b0}};
         count_d  = {CW{1'b0}};
      end else begin
         if (enq_i) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + PW'(1'b1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (deq_i) begin
            rd_ptr_d = rd_ptr_q + PW'(1'b1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({enq_i, deq_i})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
         endcase
      end
   end

   // FIFO state registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < ELS; i++) begin
            mem_q[i] <= {W{1'b0}};
         end
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == CW'(ELS));
   assign empty_o = (count_q == {CW{1'b0}});

endmodule

module mc_axil_fifo_bridge #(
   parameter int C_S00_AXI_DATA_WIDTH = 32,
   parameter int C_S00_AXI_ADDR_WIDTH = 6,
   parameter int fifo_els_p           = 8
) (
   input  logic                                s00_axi_aclk,
   input  logic                                s00_axi_aresetn,
   input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
   input  logic [2:0]                          s00_axi_awprot,
   input  logic                                s00_axi_awvalid,
   output logic                                s00_axi_awready,
   input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
   input  logic [(C_S00_AXI_DATA_WIDTH/8)-1:0] s00_axi_wstrb,
   input  logic                                s00_axi_wvalid,
   output logic                                s00_axi_wready,
   output logic [1:0]                          s00_axi_bresp,
   output logic                                s00_axi_bvalid,
   input  logic                                s00_axi_bready,
   input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
   input  logic [2:0]                          s00_axi_arprot,
   input  logic                                s00_axi_arvalid,
   output logic                                s00_axi_arready,
   output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
   output logic [1:0]                          s00_axi_rresp,
   output logic                                s00_axi_rvalid,
   input  logic                                s00_axi_rready,
   output logic                                ps2pl_v_o,
   output logic [C_S00_AXI_DATA_WIDTH-1:0]     ps2pl_data_o,
   input  logic                                ps2pl_yumi_i,
   input  logic                                pl2ps_v_i,
   input  logic [C_S00_AXI_DATA_WIDTH-1:0]     pl2ps_data_i,
   output logic                                pl2ps_ready_o
);
   localparam int DW = C_S00_AXI_DATA_WIDTH;
   localparam int AW = C_S00_AXI_ADDR_WIDTH;
   localparam int CW = $clog2(fifo_els_p) + 1;
   localparam int IW = AW - 2;

   localparam logic [IW-1:0] IDX_PUSH = IW'(3'd0);
   localparam logic [IW-1:0] IDX_FREE = IW'(3'd1);
   localparam logic [IW-1:0] IDX_POP  = IW'(3'd2);
   localparam logic [IW-1:0] IDX_OCC  = IW'(3'd3);
   localparam logic [IW-1:0] IDX_CTRL = IW'(3'd4);
   localparam logic [IW-1:0] IDX_STAT = IW'(3'd5);
   localparam logic [1:0]    RESP_OKAY   = 2'b00;
   localparam logic [1:0]    RESP_SLVERR = 2'b10;

   logic          aw_ready_q, aw_ready_d;
   logic          b_valid_q, b_valid_d;
   logic [1:0]    b_resp_q, b_resp_d;
   logic          ar_ready_q, ar_ready_d;
   logic          r_valid_q, r_valid_d;
   logic [1:0]    r_resp_q, r_resp_d;
   logic [DW-1:0] r_data_q, r_data_d;
   logic          ctrl_q, ctrl_d;
   logic [1:0]    status_q, status_d;
   logic          init_q, init_d;

   logic [IW-1:0] wr_idx_s, rd_idx_s;
   logic          wr_acc_s, rd_acc_s, wr_mapped_s;
   logic          push_req_s, push_ok_s, pop_req_s;
   logic          ps2pl_enq_s, ps2pl_deq_s, ps2pl_full_s, ps2pl_empty_s;
   logic          pl2ps_enq_s, pl2ps_deq_s, pl2ps_full_s, pl2ps_empty_s;
   logic [CW-1:0] ps2pl_count_s, pl2ps_count_s, ps2pl_free_s;
   logic [DW-1:0] pl2ps_head_s;
   logic [1:0]    w1c_s;
   logic          unused_s;

   assign unused_s = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_wstrb,
                       s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

   assign wr_idx_s    = s00_axi_awaddr[AW-1:2];
   assign rd_idx_s    = s00_axi_araddr[AW-1:2];
   assign wr_acc_s    = aw_ready_q & s00_axi_awvalid & s00_axi_wvalid;
   assign rd_acc_s    = ar_ready_q & s00_axi_arvalid;
   assign wr_mapped_s = (wr_idx_s <= IDX_STAT);

   // a push into a full FIFO still lands when the consumer frees the head that cycle
   assign ps2pl_deq_s  = ps2pl_yumi_i & ~ps2pl_empty_s;
   assign push_req_s   = wr_acc_s & (wr_idx_s == IDX_PUSH);
   assign push_ok_s    = ~ps2pl_full_s | ps2pl_deq_s;
   assign ps2pl_enq_s  = push_req_s & push_ok_s;
   assign pop_req_s    = rd_acc_s & (rd_idx_s == IDX_POP);
   assign pl2ps_deq_s  = pop_req_s & ~pl2ps_empty_s;
   assign pl2ps_enq_s  = pl2ps_v_i & pl2ps_ready_o;
   assign ps2pl_free_s = CW'(fifo_els_p) - ps2pl_count_s;
   assign w1c_s        = (wr_acc_s && (wr_idx_s == IDX_STAT)) ? s00_axi_wdata[1:0] : 2'b00;

   mc_axil_fifo_bridge_fifo #(.W(DW), .ELS(fifo_els_p)) u_ps2pl (
      .clk_i   (s00_axi_aclk),
      .rst_ni  (s00_axi_aresetn),
      .clr_i   (ctrl_q),
      .enq_i   (ps2pl_enq_s),
      .deq_i   (ps2pl_deq_s),
      .data_i  (s00_axi_wdata),
      .data_o  (ps2pl_data_o),
      .count_o (ps2pl_count_s),
      .full_o  (ps2pl_full_s),
      .empty_o (ps2pl_empty_s)
   );

   mc_axil_fifo_bridge_fifo #(.W(DW), .ELS(fifo_els_p)) u_pl2ps (
      .clk_i   (s00_axi_aclk),
      .rst_ni  (s00_axi_aresetn),
      .clr_i   (ctrl_q),
      .enq_i   (pl2ps_enq_s),
      .deq_i   (pl2ps_deq_s),
      .data_i  (pl2ps_data_i),
      .data_o  (pl2ps_head_s),
      .count_o (pl2ps_count_s),
      .full_o  (pl2ps_full_s),
      .empty_o (pl2ps_empty_s)
   );

   // write channel, control pulse and sticky status next-state
   always_comb begin
      aw_ready_d = 1'b0;
      b_valid_d  = b_valid_q;
      b_resp_d   = b_resp_q;
      if (!aw_ready_q && s00_axi_awvalid && s00_axi_wvalid && !b_valid_q) begin
         aw_ready_d = 1'b1;
      end else begin
         aw_ready_d = 1'b0;
      end
      if (wr_acc_s) begin
         b_valid_d = 1'b1;
         b_resp_d  = wr_mapped_s ? RESP_OKAY : RESP_SLVERR;
      end else if (s00_axi_bready) begin
         b_valid_d = 1'b0;
      end else begin
         b_valid_d = b_valid_q;
      end
      ctrl_d   = wr_acc_s & (wr_idx_s == IDX_CTRL) & s00_axi_wdata[0];
      status_d = (status_q & ~w1c_s) | {pop_req_s & pl2ps_empty_s, push_req_s & ~push_ok_s};
      init_d   = 1'b1;
   end

   // read channel next-state; data captured at the address handshake
   always_comb begin
      ar_ready_d = 1'b0;
      r_valid_d  = r_valid_q;
      r_resp_d   = r_resp_q;
      r_data_d   = r_data_q;
      if (!ar_ready_q && s00_axi_arvalid && !r_valid_q) begin
         ar_ready_d = 1'b1;
      end else begin
         ar_ready_d = 1'b0;
      end
      if (rd_acc_s) begin
         r_valid_d = 1'b1;
         r_resp_d  = RESP_OKAY;
         case (rd_idx_s)
            IDX_PUSH: r_data_d = {DW{1'b0}};
            IDX_FREE: r_data_d = DW'(ps2pl_free_s);
            IDX_POP:  r_data_d = pl2ps_empty_s ? {DW{1'b0}} : pl2ps_head_s;
            IDX_OCC:  r_data_d = DW'(pl2ps_count_s);
            IDX_CTRL: r_data_d = DW'(ctrl_q);
            IDX_STAT: r_data_d = DW'(status_q);
            default: begin
               r_data_d = {DW{1'b0}};
               r_resp_d = RESP_SLVERR;
            end
         endcase
      end else if (s00_axi_rready) begin
         r_valid_d = 1'b0;
      end else begin
         r_valid_d = r_valid_q;
      end
   end

   // bridge state registers
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         aw_ready_q <= 1'b0;
         b_valid_q  <= 1'b0;
         b_resp_q   <= 2'b00;
         ar_ready_q <= 1'b0;
         r_valid_q  <= 1'b0;
         r_resp_q   <= 2'b00;
         r_data_q   <= {DW{1'b0}};
         ctrl_q     <= 1'b0;
         status_q   <= 2'b00;
         init_q     <= 1'b0;
      end else begin
         aw_ready_q <= aw_ready_d;
         b_valid_q  <= b_valid_d;
         b_resp_q   <= b_resp_d;
         ar_ready_q <= ar_ready_d;
         r_valid_q  <= r_valid_d;
         r_resp_q   <= r_resp_d;
         r_data_q   <= r_data_d;
         ctrl_q     <= ctrl_d;
         status_q   <= status_d;
         init_q     <= init_d;
      end
   end

   assign s00_axi_awready = aw_ready_q;
   assign s00_axi_wready  = aw_ready_q;
   assign s00_axi_bvalid  = b_valid_q;
   assign s00_axi_bresp   = b_resp_q;
   assign s00_axi_arready = ar_ready_q;
   assign s00_axi_rvalid  = r_valid_q;
   assign s00_axi_rresp   = r_resp_q;
   assign s00_axi_rdata   = r_data_q;
   assign ps2pl_v_o       = ~ps2pl_empty_s;
   assign pl2ps_ready_o   = init_q & ~pl2ps_full_s;

endmodule

// File: tb/tb_mc_axil_fifo_bridge.sv
// Self-checking bench for mc_axil_fifo_bridge: register table, FIFO scoreboards and
// hand-written sequences for full/empty, stalled read and mid-transaction reset.

module tb_mc_axil_fifo_bridge;
   localparam int DW = 32;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] awaddr, araddr;
   logic [2:0]    awprot, arprot;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic [DW-1:0] wdata, rdata, ps2pl_data, pl2ps_data;
   logic [3:0]    wstrb;
   logic [1:0]    bresp, rresp;
   logic          arvalid, arready, rvalid, rready;
   logic          ps2pl_v, ps2pl_yumi, pl2ps_v, pl2ps_ready;

   always #5 clk = ~clk;

   mc_axil_fifo_bridge #(.C_S00_AXI_DATA_WIDTH(DW), .C_S00_AXI_ADDR_WIDTH(AW), .fifo_els_p(8)) dut (
      .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
      .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
      .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
      .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
      .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
      .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
      .ps2pl_v_o(ps2pl_v), .ps2pl_data_o(ps2pl_data), .ps2pl_yumi_i(ps2pl_yumi),
      .pl2ps_v_i(pl2ps_v), .pl2ps_data_i(pl2ps_data), .pl2ps_ready_o(pl2ps_ready)
   );

   typedef struct {
      bit            wr;
      logic [AW-1:0] addr;
      logic [31:0]   wdata;
      logic [1:0]    resp;
      logic [31:0]   rdata;
      string         name;
   } vec_t;

   typedef struct {
      logic [1:0]  resp;
      logic [31:0] rdata;
      string       name;
   } exp_t;

   int          tests_run = 0;
   int          failed = 0;
   logic [31:0] ps_q[$];
   logic [31:0] pl_q[$];
   exp_t        sb_q[$];
   vec_t        vecs[13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // Entered at a negedge; returns at a negedge after the response is consumed.
   task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, output logic [1:0] r);
      bit ok = 1'b0;
      awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (awready) begin ok = 1'b1; break; end
      end
      r = 2'b11;
      if (!ok) begin
         awvalid = 1'b0; wvalid = 1'b0;
         chk("aw_timeout", 32'd0, 32'd1);
         return;
      end
      chk("wready_with_awready", 32'(wready), 32'd1);
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      chk("bvalid_next_cycle", 32'(bvalid), 32'd1);
      r = bresp;
      @(negedge clk);
   endtask

   task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] r);
      bit ok = 1'b0;
      araddr = a; arvalid = 1'b1;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (arready) begin ok = 1'b1; break; end
      end
      d = 32'd0; r = 2'b11;
      if (!ok) begin
         arvalid = 1'b0;
         chk("ar_timeout", 32'd0, 32'd1);
         return;
      end
      @(negedge clk);
      arvalid = 1'b0;
      chk("rvalid_next_cycle", 32'(rvalid), 32'd1);
      d = rdata; r = rresp;
      @(negedge clk);
   endtask

   task automatic rd_chk(input logic [AW-1:0] a, input logic [31:0] ed, input logic [1:0] er, input string nm);
      logic [31:0] d;
      logic [1:0]  r;
      exp_t        e;
      sb_q.push_back('{er, ed, nm});
      axi_read(a, d, r);
      e = sb_q.pop_front();
      chk({e.name, "_rdata"}, d, e.rdata);
      chk({e.name, "_rresp"}, 32'(r), 32'(e.resp));
   endtask

   task automatic wr_chk(input logic [AW-1:0] a, input logic [31:0] d, input logic [1:0] er, input string nm);
      logic [1:0] r;
      axi_write(a, d, r);
      chk({nm, "_bresp"}, 32'(r), 32'(er));
   endtask

   task automatic ps_push(input logic [31:0] d);
      if (ps_q.size() < 8) ps_q.push_back(d);
      wr_chk(6'h00, d, 2'b00, "ps_push");
   endtask

   task automatic ps_pop();
      logic [31:0] e;
      e = ps_q.pop_front();
      chk("ps2pl_v", 32'(ps2pl_v), 32'd1);
      chk("ps2pl_data", ps2pl_data, e);
      ps2pl_yumi = 1'b1;
      @(negedge clk);
      ps2pl_yumi = 1'b0;
   endtask

   task automatic pl_push(input logic [31:0] d);
      chk("pl2ps_ready_before_enq", 32'(pl2ps_ready), 32'd1);
      pl2ps_v = 1'b1; pl2ps_data = d;
      pl_q.push_back(d);
      @(negedge clk);
      pl2ps_v = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] tmp;
      awaddr = '0; araddr = '0; awprot = 3'd0; arprot = 3'd0; wstrb = 4'hF;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; wdata = '0;
      bready = 1'b1; rready = 1'b1; ps2pl_yumi = 1'b0; pl2ps_v = 1'b0; pl2ps_data = '0;

      vecs[0]  = '{1'b0, 6'h0C, 32'h0,        2'b00, 32'h0, "occ_empty"};
      vecs[1]  = '{1'b0, 6'h20, 32'h0,        2'b10, 32'h0, "rd_unmapped"};
      vecs[2]  = '{1'b1, 6'h24, 32'h12345678, 2'b10, 32'h0, "wr_unmapped"};
      vecs[3]  = '{1'b1, 6'h04, 32'h5,        2'b00, 32'h0, "wr_ro_free"};
      vecs[4]  = '{1'b0, 6'h05, 32'h0,        2'b00, 32'h7, "free_lowbits"};
      vecs[5]  = '{1'b0, 6'h14, 32'h0,        2'b00, 32'h0, "status_clean"};
      vecs[6]  = '{1'b0, 6'h08, 32'h0,        2'b00, 32'h0, "pop_empty"};
      vecs[7]  = '{1'b0, 6'h14, 32'h0,        2'b00, 32'h2, "status_unf"};
      vecs[8]  = '{1'b1, 6'h16, 32'h2,        2'b00, 32'h0, "w1c_unf"};
      vecs[9]  = '{1'b0, 6'h14, 32'h0,        2'b00, 32'h0, "status_cleared"};
      vecs[10] = '{1'b0, 6'h10, 32'h0,        2'b00, 32'h0, "ctrl_idle"};
      vecs[11] = '{1'b0, 6'h3C, 32'h0,        2'b10, 32'h0, "rd_top"};
      vecs[12] = '{1'b1, 6'h08, 32'hFFFFFFFF, 2'b00, 32'h0, "wr_ro_pop"};

      // Reset values and release
      repeat (3) @(negedge clk);
      chk("rst_handshake", 32'({awready, wready, bvalid, arready, rvalid}), 32'd0);
      chk("rst_fifo_side", 32'({ps2pl_v, pl2ps_ready}), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_resp", 32'({bresp, rresp}), 32'd0);
      rst_n = 1'b1;
      #1 chk("ready_in_release_cycle", 32'(pl2ps_ready), 32'd0);
      @(negedge clk);
      chk("ready_after_release", 32'(pl2ps_ready), 32'd1);

      // First push, head visible, free slots
      ps_push(32'hDEADBEEF);
      chk("head_valid", 32'(ps2pl_v), 32'd1);
      chk("head_data", ps2pl_data, 32'hDEADBEEF);
      rd_chk(6'h04, 32'd7, 2'b00, "free_after_one");

      for (int i = 0; i < 13; i++) begin
         if (vecs[i].wr) wr_chk(vecs[i].addr, vecs[i].wdata, vecs[i].resp, vecs[i].name);
         else            rd_chk(vecs[i].addr, vecs[i].rdata, vecs[i].resp, vecs[i].name);
      end
      ps_pop();
      chk("ps2pl_drained", 32'(ps2pl_v), 32'd0);

      // Overflow of the host-to-PL FIFO
      for (int i = 0; i < 9; i++) ps_push(32'h100 + 32'(i));
      rd_chk(6'h04, 32'd0, 2'b00, "free_full");
      rd_chk(6'h14, 32'd1, 2'b00, "status_ovf");
      wr_chk(6'h14, 32'd1, 2'b00, "w1c_ovf");
      rd_chk(6'h14, 32'd0, 2'b00, "status_ovf_cleared");
      for (int i = 0; i < 8; i++) ps_pop();
      chk("ps2pl_empty_after_drain", 32'(ps2pl_v), 32'd0);

      // PL-to-host fill, ordered drain, underflow
      for (int i = 1; i <= 8; i++) pl_push(32'(i));
      chk("pl2ps_not_ready_full", 32'(pl2ps_ready), 32'd0);
      rd_chk(6'h0C, 32'd8, 2'b00, "occ_full");
      for (int i = 0; i < 8; i++) begin
         tmp = pl_q.pop_front();
         rd_chk(6'h08, tmp, 2'b00, "pop_order");
      end
      rd_chk(6'h08, 32'd0, 2'b00, "pop_ninth");
      rd_chk(6'h14, 32'd2, 2'b00, "status_unf_9th");
      wr_chk(6'h14, 32'd2, 2'b00, "w1c_unf_9th");

      // Full FIFO with enqueue attempt and pop in the same cycle
      for (int i = 0; i < 8; i++) pl_push(32'h11 + 32'(i));
      araddr = 6'h08; arvalid = 1'b1; pl2ps_v = 1'b1; pl2ps_data = 32'h99;
      @(negedge clk);
      chk("full_pop_arready", 32'(arready), 32'd1);
      chk("full_ready_pre_deq", 32'(pl2ps_ready), 32'd0);
      @(negedge clk);
      arvalid = 1'b0;
      chk("full_pop_rvalid", 32'(rvalid), 32'd1);
      tmp = pl_q.pop_front();
      chk("full_pop_rdata", rdata, tmp);
      chk("full_ready_after_deq", 32'(pl2ps_ready), 32'd1);
      pl_q.push_back(32'h99);
      @(negedge clk);
      pl2ps_v = 1'b0;
      rd_chk(6'h0C, 32'd8, 2'b00, "occ_after_swap");
      for (int i = 0; i < 8; i++) begin
         tmp = pl_q.pop_front();
         rd_chk(6'h08, tmp, 2'b00, "pop_after_swap");
      end

      // Stalled read response stays stable
      rready = 1'b0; araddr = 6'h20; arvalid = 1'b1;
      for (int t = 0; t < 20 && !arready; t++) @(negedge clk);
      chk("stall_arready", 32'(arready), 32'd1);
      @(negedge clk);
      arvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("stall_rvalid", 32'(rvalid), 32'd1);
         chk("stall_rdata", rdata, 32'd0);
         chk("stall_rresp", 32'(rresp), 32'd2);
         @(negedge clk);
      end
      rready = 1'b1;
      @(negedge clk);
      chk("stall_released", 32'(rvalid), 32'd0);

      // Control clear empties both FIFOs
      ps_push(32'hA1);
      ps_push(32'hA2);
      pl_push(32'h77);
      wr_chk(6'h10, 32'd1, 2'b00, "ctrl_clear");
      ps_q.delete();
      pl_q.delete();
      chk("clear_ps2pl_v", 32'(ps2pl_v), 32'd0);
      rd_chk(6'h04, 32'd8, 2'b00, "free_after_clear");
      rd_chk(6'h0C, 32'd0, 2'b00, "occ_after_clear");
      rd_chk(6'h10, 32'd0, 2'b00, "ctrl_selfclear");
      rd_chk(6'h14, 32'd0, 2'b00, "status_after_clear");

      // Reset while a write response waits for bready
      pl_push(32'h33);
      bready = 1'b0; awaddr = 6'h00; wdata = 32'h55; awvalid = 1'b1; wvalid = 1'b1;
      for (int t = 0; t < 20 && !awready; t++) @(negedge clk);
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      chk("bvalid_held", 32'(bvalid), 32'd1);
      #2 rst_n = 1'b0;
      #1 chk("rst_kills_bvalid", 32'(bvalid), 32'd0);
      chk("rst_mid_outs", 32'({awready, arready, rvalid, ps2pl_v, pl2ps_ready}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; bready = 1'b1;
      ps_q.delete();
      pl_q.delete();
      @(negedge clk);
      rd_chk(6'h04, 32'd8, 2'b00, "free_after_rst");
      rd_chk(6'h0C, 32'd0, 2'b00, "occ_after_rst");

      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
